// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU operation selects and forwarding selects.
package execute_stage_pkg;

    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned FWD_W    = 2;
    localparam int unsigned REG_W    = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b101;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Execute-stage ALU: add/sub/and/or/signed slt; unused encodings yield 0.
module alu
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [XLEN-1:0]     result,
    output logic                zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = XLEN'($signed(a) < $signed(b));
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// RISC-V execute stage: operand forwarding, ALU, branch resolution and EX/MEM register.
// Optional macro EX_STALL_FLUSH_EN adds StallM/FlushM control of the EX/MEM register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     RD1E,
    input  logic [XLEN-1:0]     RD2E,
    input  logic [XLEN-1:0]     ImmExtE,
    input  logic [XLEN-1:0]     PCE,
    input  logic [XLEN-1:0]     PCplus4E,
    input  logic [REG_W-1:0]    RdE,
    input  logic                RegWriteE,
    input  logic                ResultSrcE,
    input  logic                MemwriteE,
    input  logic                JumpE,
    input  logic                BranchE,
    input  logic                ALUSrcE,
    input  logic [ALU_OP_W-1:0] ALUControlE,
    input  logic [FWD_W-1:0]    ForwardAE,
    input  logic [FWD_W-1:0]    ForwardBE,
    input  logic [XLEN-1:0]     ResultW,
`ifdef EX_STALL_FLUSH_EN
    input  logic                StallM,
    input  logic                FlushM,
`endif
    output logic [XLEN-1:0]     ALUresultM,
    output logic [XLEN-1:0]     WriteDataM,
    output logic [XLEN-1:0]     PCplus4M,
    output logic [REG_W-1:0]    RdM,
    output logic                RegWriteM,
    output logic                ResultSrcM,
    output logic                MemwriteM,
    output logic                PCSrcE,
    output logic [XLEN-1:0]     PCTargetE
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Forwarding muxes; the MEM leg takes last cycle's registered ALU result.
    always_comb begin
        src_a = RD1E;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUresultM;
            default: src_a = RD1E;
        endcase
    end

    always_comb begin
        write_data = RD2E;
        case (ForwardBE)
            FWD_WB:  write_data = ResultW;
            FWD_MEM: write_data = ALUresultM;
            default: write_data = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : write_data;

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .a      (src_a),
        .b      (src_b),
        .op     (ALUControlE),
        .result (alu_result),
        .zero   (zero)
    );

    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = JumpE | (BranchE & zero);

    // EX/MEM pipeline register; a flush inserts a bubble and wins over a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUresultM <= '0;
            WriteDataM <= '0;
            PCplus4M   <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            MemwriteM  <= 1'b0;
`ifdef EX_STALL_FLUSH_EN
        end else if (FlushM) begin
            ALUresultM <= '0;
            WriteDataM <= '0;
            PCplus4M   <= '0;
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            MemwriteM  <= 1'b0;
        end else if (!StallM) begin
`else
        end else begin
`endif
            ALUresultM <= alu_result;
            WriteDataM <= write_data;
            PCplus4M   <= PCplus4E;
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            MemwriteM  <= MemwriteE;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against a behavioural pipeline model.
module tb_execute_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     RD1E, RD2E, ImmExtE, PCE, PCplus4E, ResultW;
    logic [4:0]      RdE;
    logic            RegWriteE, ResultSrcE, MemwriteE, JumpE, BranchE, ALUSrcE;
    logic [2:0]      ALUControlE;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            StallM = 1'b0;
    logic            FlushM = 1'b0;
    logic [31:0]     ALUresultM, WriteDataM, PCplus4M, PCTargetE;
    logic [4:0]      RdM;
    logic            RegWriteM, ResultSrcM, MemwriteM, PCSrcE;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // Model of the EX/MEM register contents.
    logic [31:0] m_alu = '0, m_wd = '0, m_pc4 = '0;
    logic [4:0]  m_rd = '0;
    logic        m_rw = 1'b0, m_rs = 1'b0, m_mw = 1'b0;

    execute_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCplus4E(PCplus4E),
        .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemwriteE(MemwriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
`ifdef EX_STALL_FLUSH_EN
        .StallM(StallM), .FlushM(FlushM),
`endif
        .ALUresultM(ALUresultM), .WriteDataM(WriteDataM), .PCplus4M(PCplus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemwriteM(MemwriteM),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd();
        return pick(ForwardBE, RD2E, ResultW, m_alu);
    endfunction

    function automatic logic [31:0] exp_alu();
        return alu_ref(ALUControlE, pick(ForwardAE, RD1E, ResultW, m_alu),
                       ALUSrcE ? ImmExtE : exp_wd());
    endfunction

    function automatic logic exp_pcsrc();
        return JumpE | (BranchE & (exp_alu() == 32'd0));
    endfunction

    task automatic zero_model();
        m_alu = '0; m_wd = '0; m_pc4 = '0; m_rd = '0; m_rw = 1'b0; m_rs = 1'b0; m_mw = 1'b0;
    endtask

    // Advance one clock and mirror what the EX/MEM register must have done.
    task automatic cycle();
        logic [31:0] na, nw;
        na = exp_alu();
        nw = exp_wd();
        @(posedge clk);
        #1;
        if (!rst || FlushM) zero_model();
        else if (!StallM) begin
            m_alu = na; m_wd = nw; m_pc4 = PCplus4E; m_rd = RdE;
            m_rw = RegWriteE; m_rs = ResultSrcE; m_mw = MemwriteE;
        end
    endtask

    task automatic randomize_inputs();
        RD1E = $urandom; RD2E = $urandom; PCE = $urandom; PCplus4E = $urandom;
        ResultW = $urandom; RdE = 5'($urandom);
        ImmExtE = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        if ($urandom_range(0, 3) == 0) RD2E = RD1E;
        {RegWriteE, ResultSrcE, MemwriteE, JumpE, BranchE, ALUSrcE} = 6'($urandom);
        ALUControlE = 3'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    endtask

    task automatic clear_inputs();
        RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; PCplus4E = '0; ResultW = '0; RdE = '0;
        {RegWriteE, ResultSrcE, MemwriteE, JumpE, BranchE, ALUSrcE} = '0;
        ALUControlE = '0; ForwardAE = '0; ForwardBE = '0;
    endtask

    task automatic chk_regs_zero(input string tag);
        chk({tag, "_alu"}, ALUresultM, 32'd0);
        chk({tag, "_wd"},  WriteDataM, 32'd0);
        chk({tag, "_pc4"}, PCplus4M, 32'd0);
        chk({tag, "_ctl"}, {24'd0, RdM, RegWriteM, ResultSrcM, MemwriteM}, 32'd0);
    endtask

    // Compare process: registered and combinational outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("ALUresultM", ALUresultM, m_alu);
            chk("WriteDataM", WriteDataM, m_wd);
            chk("PCplus4M",   PCplus4M, m_pc4);
            chk("RdM",        32'(RdM), 32'(m_rd));
            chk("ctlM", {29'd0, RegWriteM, ResultSrcM, MemwriteM}, {29'd0, m_rw, m_rs, m_mw});
            chk("PCTargetE",  PCTargetE, PCE + ImmExtE);
            chk("PCSrcE",     32'(PCSrcE), 32'(exp_pcsrc()));
        end
    end

    initial begin
        rst = 1'b0;
        randomize_inputs();
        #2;
        chk_regs_zero("reset_noclk");
        @(negedge clk);
        rst = 1'b1;
        started = 1'b1;

        // Add with immediate.
        clear_inputs();
        RD1E = 32'd5; ImmExtE = 32'd7; ALUSrcE = 1'b1;
        cycle();
        chk("add_imm", ALUresultM, 32'd12);

        // Back-to-back forwarding from the registered ALU result and from writeback.
        clear_inputs();
        RD1E = 32'h10; ALUSrcE = 1'b1; RdE = 5'd3; RegWriteE = 1'b1;
        cycle();
        chk("fwd_first", ALUresultM, 32'h10);
        chk("fwd_first_rd", 32'(RdM), 32'd3);
        clear_inputs();
        ForwardAE = 2'b10; ImmExtE = 32'd1; ALUSrcE = 1'b1;
        ForwardBE = 2'b01; ResultW = 32'hAB; RD2E = 32'h55; MemwriteE = 1'b1;
        cycle();
        chk("fwd_mem_a", ALUresultM, 32'h11);
        chk("fwd_wb_b", WriteDataM, 32'hAB);
        chk("fwd_memwrite", 32'(MemwriteM), 32'd1);

        // Branch resolution in the same cycle.
        clear_inputs();
        RD1E = 32'd9; RD2E = 32'd9; ALUControlE = 3'b001; BranchE = 1'b1;
        PCE = 32'h100; ImmExtE = 32'h20;
        #1;
        chk("br_taken", 32'(PCSrcE), 32'd1);
        chk("br_target", PCTargetE, 32'h120);
        RD2E = 32'd8;
        #1;
        chk("br_not_taken", 32'(PCSrcE), 32'd0);
        cycle();

        // Signed set-less-than and wrap-around add.
        clear_inputs();
        RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUControlE = 3'b101;
        cycle();
        chk("slt_neg", ALUresultM, 32'd1);
        ALUControlE = 3'b000; BranchE = 1'b1;
        #1;
        chk("wrap_zero", 32'(PCSrcE), 32'd1);
        cycle();
        chk("wrap_add", ALUresultM, 32'd0);
        ALUControlE = 3'b110;
        cycle();
        chk("op110_zero", ALUresultM, 32'd0);

        // Random stream.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
`ifdef EX_STALL_FLUSH_EN
            StallM = ($urandom_range(0, 4) == 0);
            FlushM = ($urandom_range(0, 9) == 0);
`endif
            cycle();
        end

`ifdef EX_STALL_FLUSH_EN
        // Stall holds, flush overrides stall.
        StallM = 1'b0; FlushM = 1'b0;
        clear_inputs();
        RD1E = 32'h33; ImmExtE = 32'h4; ALUSrcE = 1'b1; PCplus4E = 32'h44; MemwriteE = 1'b1;
        cycle();
        StallM = 1'b1;
        RD1E = 32'h77;
        cycle();
        cycle();
        chk("stall_hold_alu", ALUresultM, 32'h37);
        chk("stall_hold_pc4", PCplus4M, 32'h44);
        FlushM = 1'b1;
        cycle();
        chk_regs_zero("flush");
        StallM = 1'b0; FlushM = 1'b0;
`endif

        // Asynchronous reset mid-stream discards the in-flight instruction.
        clear_inputs();
        RD1E = 32'hDEAD; ImmExtE = 32'h1; ALUSrcE = 1'b1; RegWriteE = 1'b1; MemwriteE = 1'b1;
        cycle();
        chk("pre_reset", ALUresultM, 32'hDEAE);
        #2;
        rst = 1'b0;
        #1;
        chk_regs_zero("reset_async");
        zero_model();
        cycle();
        #1;
        rst = 1'b1;
        RD1E = 32'h20;
        cycle();
        chk("post_reset", ALUresultM, 32'h21);

        for (int i = 0; i < 50; i++) begin
            randomize_inputs();
            cycle();
        end

        @(negedge clk);
        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
